picobus_wishbone_bridge: RTL and testbench
==========================================

PICOBUS_WISHBONE_BRIDGE -- requirements
Module: picobus_wishbone_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of BUSY-state clocks without in_wb_ack or in_wb_err before the bridge aborts the Wishbone cycle.
REQ-002 in_clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 in_reset  input  1  asynchronous, active-low reset.
REQ-004 in_pico_valid  input  1  PicoBus request valid; held by the master until it has seen out_pico_ready.
REQ-005 in_pico_address  input  32  PicoBus byte address.
REQ-006 in_pico_wstrobe  input  4  byte write strobes; 4'b0000 means read, any nonzero value means write.
REQ-007 in_pico_wdata  input  32  write data.
REQ-008 out_pico_ready  output  1  one-cycle transfer-complete pulse.
REQ-009 out_pico_error  output  1  error flag, valid only while out_pico_ready=1.
REQ-010 out_pico_rdata  output  32  read data, valid while out_pico_ready=1.
REQ-011 out_wb_cyc, out_wb_stb  output  1 each  Wishbone cycle and strobe.
REQ-012 out_wb_we  output  1  Wishbone write enable.
REQ-013 out_wb_adr  output  22  Wishbone word address.
REQ-014 out_wb_sel  output  4  Wishbone byte selects.
REQ-015 out_wb_wdat  output  32  Wishbone write data.
REQ-016 in_wb_ack, in_wb_err  input  1 each  slave acknowledge and slave error.
REQ-017 in_wb_rdat  input  32  slave read data.

Function
REQ-018 The bridge SHALL implement a three-state FSM with states IDLE, BUSY and RELEASE; all outputs SHALL be registered.
REQ-019 IDLE -> BUSY SHALL occur on the first rising edge with in_pico_valid=1; one cycle later out_wb_cyc=out_wb_stb=1.
REQ-020 On that edge the bridge SHALL latch the Wishbone request fields: out_wb_adr = in_pico_address[23:2]; out_wb_we = |in_pico_wstrobe; out_wb_sel = in_pico_wstrobe for a write, 4'b1111 for a read; out_wb_wdat = in_pico_wdata.
REQ-021 The latched request fields SHALL stay constant throughout BUSY, regardless of changes on the PicoBus inputs.
REQ-022 In BUSY, on an edge sampling in_wb_err=1, the bridge SHALL:
- go to RELEASE;
- deassert cyc/stb;
- pulse out_pico_ready=1 and out_pico_error=1 for exactly one cycle;
- set out_pico_rdata=0.
REQ-023 In BUSY, on an edge sampling in_wb_ack=1 with in_wb_err=0, the bridge SHALL:
- go to RELEASE;
- deassert cyc/stb;
- pulse out_pico_ready=1 with out_pico_error=0;
- set out_pico_rdata = in_wb_rdat for a read, 0 for a write.
REQ-024 If in_wb_ack and in_wb_err are sampled high together, in_wb_err SHALL take priority.
REQ-025 A BUSY cycle counter SHALL be cleared on entry to BUSY; when it reaches TIMEOUT_CYCLES with no ack/err, the bridge SHALL terminate as in REQ-022 (error completion).
REQ-026 out_pico_ready SHALL be high for exactly one clock per transfer; out_pico_error and out_pico_rdata SHALL hold their completion values until the next completion.
REQ-027 RELEASE SHALL return to IDLE only on an edge sampling in_pico_valid=0.
REQ-028 A valid signal held high after ready SHALL NOT start a second Wishbone cycle.
REQ-029 in_wb_ack, in_wb_err and in_wb_rdat SHALL be ignored in IDLE and RELEASE.
REQ-030 in_pico_valid falling during BUSY SHALL NOT abort the Wishbone cycle; the bridge SHALL complete normally and then return to IDLE.
REQ-031 Minimum transfer latency SHALL be 2 clocks from valid sampled to ready: 1 clock to assert cyc/stb, plus 1 clock for the earliest ack.

Reset
REQ-032 While in_reset=0, the FSM SHALL be forced to IDLE and every output and internal register SHALL be 0, asynchronously; this includes out_wb_cyc, out_wb_stb, out_wb_we, out_wb_adr, out_wb_sel, out_wb_wdat, out_pico_ready, out_pico_error, out_pico_rdata and the timeout counter.
REQ-033 Reset asserted mid-transfer SHALL immediately drop cyc/stb, and no ready SHALL be produced for that transfer.
REQ-034 After reset release, the first request SHALL be accepted on the first rising edge with in_pico_valid=1.

Verification
REQ-035 Read error: address 0x45000024, wstrobe 0, in_wb_err pulsed -> cyc/stb=1, adr=0x000009, sel=1111, we=0; then a one-cycle ready=1 with error=1, rdata=0; no new cycle while valid stays high.
REQ-036 Read ack: address 0x45AA0024, wstrobe 0, ack after 3 clocks with rdat=0x0000DAFA -> adr=0x2A8009; one-cycle ready=1 with error=0 and rdata=0x0000DAFA.
REQ-037 Write: address 0x45000024, wstrobe 1111, wdata 0x0000DAFA -> we=1, sel=1111, wdat=0x0000DAFA; err -> ready+error pulse.
REQ-038 Write ack: address 0x45AA0024, wstrobe 0011 -> we=1, sel=0011; ack -> ready=1, error=0, rdata=0.
REQ-039 Timeout: slave never responds -> cyc/stb drop after TIMEOUT_CYCLES clocks; one-cycle ready=1 with error=1.
REQ-040 Reset mid-BUSY: in_reset=0 -> all outputs 0 without waiting for a clock edge; after release, a new request completes normally.

Source files
------------

// File: rtl/picobus_wishbone_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : picobus_wishbone_bridge
//  Purpose  : Converts single PicoBus valid/ready transfers into classic
//             Wishbone cycles. Each PicoBus request opens one Wishbone cycle
//             that is closed by a slave ack, a slave error, or a local
//             timeout. The result goes back to the master as a one-clock
//             ready pulse.
//
//  Ports
//    in_clock         : system clock, rising-edge active
//    in_reset         : asynchronous active-low reset
//    in_pico_valid    : PicoBus request valid (held until ready is seen)
//    in_pico_address  : PicoBus byte address [31:0]
//    in_pico_wstrobe  : byte write strobes, 4'b0000 = read
//    in_pico_wdata    : PicoBus write data
//    out_pico_ready   : one-clock transfer-complete pulse
//    out_pico_error   : completion status (error), held until next completion
//    out_pico_rdata   : completion read data, held until next completion
//    out_wb_cyc/stb   : Wishbone cycle / strobe
//    out_wb_we        : Wishbone write enable
//    out_wb_adr       : Wishbone word address [21:0]
//    out_wb_sel       : Wishbone byte selects
//    out_wb_wdat      : Wishbone write data
//    in_wb_ack/err    : slave acknowledge / error
//    in_wb_rdat       : slave read data
//
//  Revision : 1.0 - initial release
// ============================================================================
module picobus_wishbone_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        in_clock,
   input  logic        in_reset,
   input  logic        in_pico_valid,
   input  logic [31:0] in_pico_address,
   input  logic [3:0]  in_pico_wstrobe,
   input  logic [31:0] in_pico_wdata,
   output logic        out_pico_ready,
   output logic        out_pico_error,
   output logic [31:0] out_pico_rdata,
   output logic        out_wb_cyc,
   output logic        out_wb_stb,
   output logic        out_wb_we,
   output logic [21:0] out_wb_adr,
   output logic [3:0]  out_wb_sel,
   output logic [31:0] out_wb_wdat,
   input  logic        in_wb_ack,
   input  logic        in_wb_err,
   input  logic [31:0] in_wb_rdat
);

   // Counter must be able to hold TIMEOUT_CYCLES itself, since the
   // incremented value is compared against it.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              cyc_q,   cyc_d;
   logic              we_q,    we_d;
   logic [21:0]       adr_q,   adr_d;
   logic [3:0]        sel_q,   sel_d;
   logic [31:0]       wdat_q,  wdat_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              is_write;

   // Only word-address bits [23:2] reach the Wishbone side.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{in_pico_address[31:24], in_pico_address[1:0]};

   assign is_write = |in_pico_wstrobe;

   // ------------------------------------------------------------------------
   // State / register update
   // ------------------------------------------------------------------------
   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         state_q <= IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         wdat_q  <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
         ready_q <= ready_d;
         error_q <= error_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      wdat_d  = wdat_q;
      ready_d = 1'b0;           // ready is only ever a single-clock pulse
      error_d = error_q;        // status and data hold until next completion
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      cnt_inc = cnt_q + CNT_ONE;

      unique case (state_q)
         IDLE: begin
            if (in_pico_valid) begin
               state_d = BUSY;
               cyc_d   = 1'b1;
               we_d    = is_write;
               adr_d   = in_pico_address[23:2];
               sel_d   = is_write ? in_pico_wstrobe : 4'b1111;
               wdat_d  = in_pico_wdata;
               cnt_d   = '0;
            end
         end

         BUSY: begin
            // Error beats ack; a real slave response on the final allowed
            // clock beats the timeout.
            if (in_wb_err) begin
               state_d = RELEASE;
               cyc_d   = 1'b0;
               ready_d = 1'b1;
               error_d = 1'b1;
               rdata_d = '0;
            end else if (in_wb_ack) begin
               state_d = RELEASE;
               cyc_d   = 1'b0;
               ready_d = 1'b1;
               error_d = 1'b0;
               rdata_d = we_q ? 32'd0 : in_wb_rdat;
            end else if (cnt_inc == TIMEOUT_LIMIT) begin
               state_d = RELEASE;
               cyc_d   = 1'b0;
               ready_d = 1'b1;
               error_d = 1'b1;
               rdata_d = '0;
               cnt_d   = cnt_inc;
            end else begin
               cnt_d   = cnt_inc;
            end
         end

         RELEASE: begin
            // Wait for the master to drop valid so a request held high
            // after ready is not mistaken for a new one.
            if (!in_pico_valid) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs come straight from flops
   // ------------------------------------------------------------------------
   assign out_wb_cyc     = cyc_q;
   assign out_wb_stb     = cyc_q;
   assign out_wb_we      = we_q;
   assign out_wb_adr     = adr_q;
   assign out_wb_sel     = sel_q;
   assign out_wb_wdat    = wdat_q;
   assign out_pico_ready = ready_q;
   assign out_pico_error = error_q;
   assign out_pico_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_picobus_wishbone_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_picobus_wishbone_bridge
//  Purpose  : Self-checking bench for picobus_wishbone_bridge. A transaction
//             model predicts, from the request and the slave's chosen
//             response, when the transfer completes and with what status.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_picobus_wishbone_bridge;

   localparam int TO = 16;

   logic        in_clock = 1'b0;
   logic        in_reset = 1'b1;
   logic        in_pico_valid = 1'b0;
   logic [31:0] in_pico_address = '0;
   logic [3:0]  in_pico_wstrobe = '0;
   logic [31:0] in_pico_wdata = '0;
   logic        out_pico_ready;
   logic        out_pico_error;
   logic [31:0] out_pico_rdata;
   logic        out_wb_cyc;
   logic        out_wb_stb;
   logic        out_wb_we;
   logic [21:0] out_wb_adr;
   logic [3:0]  out_wb_sel;
   logic [31:0] out_wb_wdat;
   logic        in_wb_ack = 1'b0;
   logic        in_wb_err = 1'b0;
   logic [31:0] in_wb_rdat = '0;

   int total = 0;
   int bad   = 0;

   picobus_wishbone_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .in_clock        (in_clock),
      .in_reset        (in_reset),
      .in_pico_valid   (in_pico_valid),
      .in_pico_address (in_pico_address),
      .in_pico_wstrobe (in_pico_wstrobe),
      .in_pico_wdata   (in_pico_wdata),
      .out_pico_ready  (out_pico_ready),
      .out_pico_error  (out_pico_error),
      .out_pico_rdata  (out_pico_rdata),
      .out_wb_cyc      (out_wb_cyc),
      .out_wb_stb      (out_wb_stb),
      .out_wb_we       (out_wb_we),
      .out_wb_adr      (out_wb_adr),
      .out_wb_sel      (out_wb_sel),
      .out_wb_wdat     (out_wb_wdat),
      .in_wb_ack       (in_wb_ack),
      .in_wb_err       (in_wb_err),
      .in_wb_rdat      (in_wb_rdat)
   );

   always #5 in_clock = ~in_clock;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] obs_wb();
      return {3'b000, out_wb_cyc, out_wb_stb, out_wb_we, out_wb_adr, out_wb_sel, out_wb_wdat};
   endfunction

   function automatic logic [63:0] obs_pico();
      return {30'd0, out_pico_ready, out_pico_error, out_pico_rdata};
   endfunction

   // kind: 0 = ack, 1 = err, 2 = ack+err together, 3 = no response.
   // delay: BUSY clock (1 = first) on which the slave responds.
   // Called at a falling edge with the bridge idle.
   task automatic run_txn(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, input int kind, input int delay,
                          input logic [31:0] rsp_data, input bit drop_early,
                          input int hold_after, input bit noise);
      logic [63:0] exp_req;
      logic [21:0] exp_adr;
      logic [3:0]  exp_sel;
      bit          wr;
      bit          timed_out;
      bit          err_exp;
      logic [31:0] rd_exp;
      int          c;

      wr        = (strb != 4'b0000);
      exp_adr   = addr[23:2];
      exp_sel   = wr ? strb : 4'b1111;
      exp_req   = {3'b000, 1'b1, 1'b1, wr, exp_adr, exp_sel, wdata};
      timed_out = (kind == 3) || (delay > TO);
      c         = timed_out ? TO : delay;
      err_exp   = timed_out || (kind != 0);
      rd_exp    = (!err_exp && !wr) ? rsp_data : 32'd0;

      in_pico_valid   = 1'b1;
      in_pico_address = addr;
      in_pico_wstrobe = strb;
      in_pico_wdata   = wdata;
      in_wb_ack       = noise;
      in_wb_err       = noise;
      in_wb_rdat      = $urandom;
      @(negedge in_clock);
      check_val("req_fields", obs_wb(), exp_req);
      check_val("ready_low_start", {63'd0, out_pico_ready}, 64'd0);

      for (int n = 1; n <= c; n++) begin
         in_pico_address = $urandom;
         in_pico_wstrobe = 4'($urandom);
         in_pico_wdata   = $urandom;
         if (drop_early) in_pico_valid = 1'b0;
         in_wb_rdat = (n == c) ? rsp_data : $urandom;
         in_wb_ack  = (n == delay) && (kind == 0 || kind == 2);
         in_wb_err  = (n == delay) && (kind == 1 || kind == 2);
         @(negedge in_clock);
         if (n < c) begin
            check_val("fields_held", obs_wb(), exp_req);
            check_val("ready_low_busy", {63'd0, out_pico_ready}, 64'd0);
         end
      end

      check_val("cyc_drop", {62'd0, out_wb_cyc, out_wb_stb}, 64'd0);
      check_val("completion", obs_pico(), {30'd0, 1'b1, err_exp, rd_exp});

      // Master has seen ready; optionally keep valid high to probe re-triggering.
      for (int h = 0; h < hold_after; h++) begin
         in_wb_ack  = noise;
         in_wb_err  = noise;
         in_wb_rdat = $urandom;
         @(negedge in_clock);
         check_val("hold_no_cycle", {62'd0, out_wb_cyc, out_pico_ready}, 64'd0);
      end
      in_pico_valid = 1'b0;
      in_wb_ack     = noise;
      in_wb_err     = noise;
      @(negedge in_clock);
      check_val("status_held", obs_pico(), {30'd0, 1'b0, err_exp, rd_exp});
      check_val("idle_no_cycle", {63'd0, out_wb_cyc}, 64'd0);
      in_wb_ack = 1'b0;
      in_wb_err = 1'b0;
   endtask

   initial begin
      // Reset asserted before the first clock edge: outputs must clear at once.
      #1 in_reset = 1'b0;
      #2;
      check_val("reset_wb", obs_wb(), 64'd0);
      check_val("reset_pico", obs_pico(), 64'd0);
      repeat (2) @(negedge in_clock);
      in_reset = 1'b1;
      @(negedge in_clock);

      // Directed cases
      run_txn(32'h4500_0024, 4'b0000, 32'h1234_5678, 1, 2, 32'hFFFF_FFFF, 1'b0, 3, 1'b0);
      run_txn(32'h45AA_0024, 4'b0000, 32'h0,         0, 3, 32'h0000_DAFA, 1'b0, 0, 1'b0);
      run_txn(32'h4500_0024, 4'b1111, 32'h0000_DAFA, 1, 1, 32'hA5A5_A5A5, 1'b0, 0, 1'b0);
      run_txn(32'h45AA_0024, 4'b0011, 32'h0000_DAFA, 0, 1, 32'hA5A5_A5A5, 1'b0, 1, 1'b0);
      run_txn(32'h0000_0100, 4'b0000, 32'h0,         3, 0, 32'h5555_5555, 1'b0, 0, 1'b0);
      run_txn(32'h00FF_FFFC, 4'b0000, 32'h0,         2, 2, 32'h1111_2222, 1'b0, 0, 1'b1);
      run_txn(32'h0012_3458, 4'b0000, 32'h0,         0, TO, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
      run_txn(32'h0012_345C, 4'b0000, 32'h0,         0, TO + 1, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
      run_txn(32'h0ABC_DEF0, 4'b0000, 32'h0,         0, 4, 32'hBEEF_0001, 1'b1, 0, 1'b1);

      // Reset in the middle of a Wishbone cycle
      in_pico_valid   = 1'b1;
      in_pico_address = 32'h0000_0040;
      in_pico_wstrobe = 4'b1111;
      in_pico_wdata   = 32'hDEAD_BEEF;
      @(negedge in_clock);
      check_val("pre_reset_cyc", {63'd0, out_wb_cyc}, 64'd1);
      #2 in_reset = 1'b0;
      #1;
      check_val("async_reset_wb", obs_wb(), 64'd0);
      check_val("async_reset_pico", obs_pico(), 64'd0);
      in_pico_valid = 1'b0;
      in_wb_ack     = 1'b1;
      @(negedge in_clock);
      @(negedge in_clock);
      check_val("reset_hold_pico", obs_pico(), 64'd0);
      in_wb_ack = 1'b0;
      in_reset  = 1'b1;
      @(negedge in_clock);
      run_txn(32'h0000_0044, 4'b0000, 32'h0, 0, 1, 32'h0BAD_F00D, 1'b0, 0, 1'b0);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         logic [3:0] s;
         s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
         run_txn($urandom, s, $urandom, int'($urandom_range(0, 3)),
                 int'($urandom_range(1, TO + 3)), $urandom,
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                 bit'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
